// File: rtl/seg7_pkg.sv
// Shared glyph table and sizing helper for the 7-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_DASH  = 7'h01;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high {a..g} glyphs, indexed by nibble value (entry 15 listed first).
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Nibble to active-high 7-segment glyph; BCD mode maps A-F to a dash.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] glyph
);

  always_comb begin
    if (!hex_mode && (nibble > 4'd9)) glyph = SEG_DASH;
    else                              glyph = GLYPH_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-aligned double buffering,
// leading-zero suppression and pin-level polarity control.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int HEX_MODE       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic [4*NUM_DIGITS-1:0]             value_in,
  input  logic [NUM_DIGITS-1:0]               dp_in,
  input  logic                                load,
  input  logic                                blank_lz,
  output logic [6:0]                          seg_out,
  output logic                                dp_out,
  output logic [NUM_DIGITS-1:0]               an_out,
  output logic [idx_width(NUM_DIGITS)-1:0]    digit_idx,
  output logic                                pending,
  output logic                                frame_done
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_INV    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic          DP_INV     = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_INV = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [PW-1:0]                 presc;
  logic [NUM_DIGITS-1:0][3:0]    active_val;
  logic [NUM_DIGITS-1:0][3:0]    pend_val;
  logic [NUM_DIGITS-1:0]         active_dp;
  logic [NUM_DIGITS-1:0]         pend_dp;
  logic                          tc;
  logic                          wrap;
  logic [3:0]                    cur_nibble;
  logic [6:0]                    glyph;
  logic [6:0]                    seg_next;
  logic [NUM_DIGITS-1:0]         an_next;
  logic [NUM_DIGITS-1:0]         lz_blank;
  logic                          zero_run;

  assign tc         = enable && (presc == PRESC_LAST);
  assign wrap       = tc && (digit_idx == IDX_LAST);
  assign cur_nibble = active_val[digit_idx];

  seg7_glyph u_glyph (
    .nibble   (cur_nibble),
    .hex_mode (HEX_MODE != 0),
    .glyph    (glyph)
  );

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run    = zero_run && (active_val[i] == 4'd0);
      lz_blank[i] = zero_run;
    end
  end

  always_comb begin
    an_next            = '0;
    an_next[digit_idx] = 1'b1;
    seg_next           = (blank_lz && lz_blank[digit_idx]) ? SEG_BLANK : glyph;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      digit_idx  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      seg_out    <= SEG_INV;
      dp_out     <= DP_INV;
      an_out     <= AN_INV;
    end else begin
      frame_done <= wrap;

      if (tc) begin
        presc     <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else if (enable) begin
        presc <= presc + 1'b1;
      end

      // A load landing on the wrap edge bypasses the pending buffer.
      if (wrap) begin
        if (load) begin
          active_val <= value_in;
          active_dp  <= dp_in;
        end else if (pending) begin
          active_val <= pend_val;
          active_dp  <= pend_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pend_val <= value_in;
        pend_dp  <= dp_in;
        pending  <= 1'b1;
      end

      if (enable) begin
        an_out  <= an_next ^ AN_INV;
        seg_out <= seg_next ^ SEG_INV;
        dp_out  <= active_dp[digit_idx] ^ DP_INV;
      end else begin
        an_out  <= AN_INV;
        seg_out <= SEG_INV;
        dp_out  <= DP_INV;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: a hex-mode instance (anodes active-low) and a BCD-mode
// instance (segments active-low, anodes active-high) share all inputs.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst, enable, load, blank_lz;
  logic [15:0] value_in;
  logic [3:0]  dp_in;

  logic [6:0] seg_h, seg_b;
  logic       dp_h, dp_b;
  logic [3:0] an_h, an_b;
  logic [1:0] idx_h, idx_b;
  logic       pend_h, pend_b, fd_h, fd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) dut_hex (
    .clk(clk), .rst(rst), .enable(enable), .value_in(value_in), .dp_in(dp_in),
    .load(load), .blank_lz(blank_lz), .seg_out(seg_h), .dp_out(dp_h), .an_out(an_h),
    .digit_idx(idx_h), .pending(pend_h), .frame_done(fd_h));

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0),
                     .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0)) dut_bcd (
    .clk(clk), .rst(rst), .enable(enable), .value_in(value_in), .dp_in(dp_in),
    .load(load), .blank_lz(blank_lz), .seg_out(seg_b), .dp_out(dp_b), .an_out(an_b),
    .digit_idx(idx_b), .pending(pend_b), .frame_done(fd_b));

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] hx;   // expected active-high glyphs, hex instance, {d3,d2,d1,d0}
    logic [3:0][6:0] bc;   // expected active-high glyphs, BCD instance
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic wait_fd();
    int n = 0;
    while (!fd_h && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (!fd_h) begin
      errors++;
      $display("FAIL wait_frame_done: got no pulse within %0d cycles, expected one", n);
    end
  endtask

  // Entered on the sample right after a wrap edge; walks one full frame.
  task automatic check_frame(input logic [3:0][6:0] hx, input logic [3:0][6:0] bc,
                             input logic [3:0] dpv);
    logic [3:0] oh, noh;
    logic [6:0] inv;
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 1 : 4) step();
      oh  = 4'b0001 << k;
      noh = ~oh;
      inv = ~bc[k];
      chk($sformatf("digit_idx d%0d", k), idx_h, k);
      chk($sformatf("digit_idx_bcd d%0d", k), idx_b, k);
      chk($sformatf("an_hex d%0d", k), an_h, noh);
      chk($sformatf("an_bcd d%0d", k), an_b, oh);
      chk($sformatf("seg_hex d%0d", k), seg_h, hx[k]);
      chk($sformatf("seg_bcd d%0d", k), seg_b, inv);
      chk($sformatf("dp_hex d%0d", k), dp_h, dpv[k]);
      chk($sformatf("dp_bcd d%0d", k), dp_b, !dpv[k]);
    end
  endtask

  task automatic chk_inactive(input string tag);
    chk({tag, " an_hex"}, an_h, 4'hF);
    chk({tag, " seg_hex"}, seg_h, 7'h00);
    chk({tag, " dp_hex"}, dp_h, 1'b0);
    chk({tag, " an_bcd"}, an_b, 4'h0);
    chk({tag, " seg_bcd"}, seg_b, 7'h7F);
    chk({tag, " dp_bcd"}, dp_b, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] e;
    vecs[0] = '{16'h1234, 4'h0, 1'b0, {7'h30, 7'h6D, 7'h79, 7'h33}, {7'h30, 7'h6D, 7'h79, 7'h33}};
    vecs[1] = '{16'h00A5, 4'h0, 1'b1, {7'h00, 7'h00, 7'h77, 7'h5B}, {7'h00, 7'h00, 7'h01, 7'h5B}};
    vecs[2] = '{16'h00A5, 4'h0, 1'b0, {7'h7E, 7'h7E, 7'h77, 7'h5B}, {7'h7E, 7'h7E, 7'h01, 7'h5B}};
    vecs[3] = '{16'hBEEF, 4'h4, 1'b0, {7'h1F, 7'h4F, 7'h4F, 7'h47}, {7'h01, 7'h01, 7'h01, 7'h01}};
    vecs[4] = '{16'h0000, 4'h9, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}, {7'h00, 7'h00, 7'h00, 7'h7E}};
    vecs[5] = '{16'h0C0D, 4'h0, 1'b1, {7'h00, 7'h4E, 7'h7E, 7'h3D}, {7'h00, 7'h01, 7'h7E, 7'h01}};
    vecs[6] = '{16'h6789, 4'hF, 1'b1, {7'h5F, 7'h70, 7'h7F, 7'h7B}, {7'h5F, 7'h70, 7'h7F, 7'h7B}};

    rst = 1'b1; enable = 1'b1; load = 1'b0; blank_lz = 1'b0;
    value_in = 16'h0000; dp_in = 4'h0;
    repeat (3) step();
    chk_inactive("reset");
    chk("reset digit_idx", idx_h, 0);
    chk("reset pending", pend_h, 0);
    chk("reset frame_done", fd_h, 0);

    // First frame after reset release: anode walk and frame_done timing.
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      e = ~(4'b0001 << (c / 4));
      chk($sformatf("scan an c%0d", c), an_h, e);
      chk($sformatf("scan frame_done c%0d", c), fd_h, (c == 15));
      chk($sformatf("scan seg c%0d", c), seg_h, 7'h7E);
    end
    chk("wrap digit_idx", idx_h, 0);

    // Mid-frame loads: last one wins, display unchanged until the wrap.
    repeat (5) step();
    value_in = 16'h4321; load = 1'b1; step(); load = 1'b0;
    chk("midframe pending", pend_h, 1);
    chk("midframe seg unchanged", seg_h, 7'h7E);
    value_in = 16'h1234; load = 1'b1; step(); load = 1'b0;
    chk("reload pending", pend_h, 1);
    wait_fd();
    chk("commit pending cleared", pend_h, 0);
    check_frame(vecs[0].hx, vecs[0].bc, vecs[0].dp);

    for (int v = 0; v < 7; v++) begin
      value_in = vecs[v].val; dp_in = vecs[v].dp; blank_lz = vecs[v].lz;
      load = 1'b1; step(); load = 1'b0;
      if (!fd_h) chk($sformatf("vec%0d pending", v), pend_h, 1);
      wait_fd();
      chk($sformatf("vec%0d committed", v), pend_h, 0);
      check_frame(vecs[v].hx, vecs[v].bc, vecs[v].dp);
    end

    // Load landing exactly on the wrap edge commits directly.
    blank_lz = 1'b0;
    wait_fd();
    repeat (15) step();
    value_in = vecs[3].val; dp_in = vecs[3].dp; load = 1'b1;
    step(); load = 1'b0;
    chk("wrapload frame_done", fd_h, 1);
    chk("wrapload pending", pend_h, 0);
    check_frame(vecs[3].hx, vecs[3].bc, vecs[3].dp);
    chk("wrapload pending after", pend_h, 0);

    // Disable at prescaler=2 on digit 1; a load while disabled waits for the wrap.
    wait_fd();
    repeat (6) step();
    chk("pre-disable digit_idx", idx_h, 1);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        value_in = vecs[6].val; dp_in = vecs[6].dp; load = 1'b1;
      end
      step();
      load = 1'b0;
      chk_inactive($sformatf("disabled c%0d", i));
      chk($sformatf("disabled digit_idx c%0d", i), idx_h, 1);
      chk($sformatf("disabled frame_done c%0d", i), fd_h, 0);
    end
    chk("disabled load pending", pend_h, 1);
    enable = 1'b1;
    step();
    chk("resume1 an", an_h, 4'hD);
    chk("resume1 digit_idx", idx_h, 1);
    step();
    chk("resume2 an", an_h, 4'hD);
    chk("resume2 digit_idx", idx_h, 2);
    step();
    chk("resume3 an", an_h, 4'hB);
    wait_fd();
    chk("disabled load committed", pend_h, 0);
    check_frame(vecs[6].hx, vecs[6].bc, vecs[6].dp);

    // Reset mid-frame with a pending value discards it and clears the active buffer.
    value_in = 16'h1111; dp_in = 4'h0; load = 1'b1; step(); load = 1'b0;
    chk("prereset pending", pend_h, 1);
    repeat (2) step();
    rst = 1'b1; step();
    chk("midreset digit_idx", idx_h, 0);
    chk("midreset pending", pend_h, 0);
    chk("midreset frame_done", fd_h, 0);
    chk_inactive("midreset");
    rst = 1'b0; step();
    chk("postreset an", an_h, 4'hE);
    chk("postreset seg", seg_h, 7'h7E);
    chk("postreset dp", dp_h, 0);
    wait_fd();
    chk("postreset no commit", pend_h, 0);
    step();
    chk("postreset seg after wrap", seg_h, 7'h7E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for an N-digit 7-segment display.
- Each digit is decoded from a 4-bit nibble in BCD or hex mode, with per-digit decimal points, leading-zero suppression and selectable output polarity.
- New values are double-buffered and take effect only at a frame boundary, so the display never tears.
- Sits between datapath counters/registers and board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; minimum 2.
- REFRESH_DIV, 1000, clk cycles each digit stays lit; minimum 2.
- HEX_MODE, 1, 1 = nibbles 0-F decoded as hex glyphs; 0 = BCD mode, nibbles >9 shown as dash.
- SEG_ACTIVE_LOW, 0, 1 = seg_out and dp_out inverted at the pins.
- AN_ACTIVE_LOW, 1, 1 = an_out inverted at the pins.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = scanning and display on; 0 = display blanked, scan frozen.
- value_in  in  4*NUM_DIGITS  digit nibbles; nibble 0 = value_in[3:0] = rightmost digit.
- dp_in  in  NUM_DIGITS  decimal point per digit; bit i goes with nibble i.
- load  in  1  one-cycle strobe; captures value_in and dp_in into the pending buffer.
- blank_lz  in  1  suppress leading zeros.
- seg_out  out  7  segments {a,b,c,d,e,f,g}, a = MSB, polarity per SEG_ACTIVE_LOW.
- dp_out  out  1  decimal point segment, polarity per SEG_ACTIVE_LOW.
- an_out  out  NUM_DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW.
- digit_idx  out  $clog2(NUM_DIGITS)  index of the digit currently driven.
- pending  out  1  a loaded value is waiting for commit.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.

Behaviour:
- Reset (sync, active-high) clears all state:
  - prescaler = 0, digit_idx = 0, active buffer = 0, pending = 0, frame_done = 0.
  - seg_out, dp_out and an_out are driven to their inactive pin levels.
- Prescaler: counts 0..REFRESH_DIV-1 while enable = 1.
  - At terminal count it returns to 0 and digit_idx advances by one.
  - Wrap from NUM_DIGITS-1 to 0 pulses frame_done on the same edge digit_idx becomes 0.
- Double buffering:
  - load copies value_in and dp_in into the pending buffer and sets pending = 1.
  - A later load before commit overwrites the pending buffer (last wins).
  - Commit happens on the wrap edge: pending buffer -> active buffer, pending cleared.
  - If load is asserted in the wrap cycle, value_in and dp_in are committed directly at that edge and pending stays 0.
  - Loads are accepted even while enable = 0; the commit waits for the next wrap.
- Outputs are registered, one cycle behind digit_idx/active-buffer state:
  - an_out is one-hot on digit_idx.
  - seg_out is the glyph of active nibble[digit_idx].
  - dp_out = active dp[digit_idx].
- Glyphs, active-high, {a..g}:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
  - A=77, b=1F, C=4E, d=3D, E=4F, F=47.
  - In BCD mode nibbles A-F produce dash 01.
- Leading-zero suppression (blank_lz = 1): digit i (i > 0) shows seg = 00 when nibbles i..NUM_DIGITS-1 are all zero.
  - Its anode still cycles.
  - dp is still shown if set.
  - Digit 0 is never suppressed.
- enable = 0: prescaler and digit_idx hold their values; next cycle all an_out, seg_out and dp_out are inactive.
  - Re-enable resumes from the held count.
- Polarity inversion is applied only at the final output register.

Decomposition:
- seg7_pkg holds the 16 glyph constants, SEG_DASH (7'h01) and SEG_BLANK (7'h00), plus the helper that computes digit-index width.
- seg7_glyph is the one combinational sub-module: nibble plus hex_mode in, 7-bit active-high glyph out.
- seg7_scan_driver instantiates seg7_glyph once, on the muxed nibble.

Test Plan:
- Reset release with NUM_DIGITS=4, REFRESH_DIV=4, AN_ACTIVE_LOW=1 -> an_out=4'hF, seg_out=00 during reset. After release, an_out steps E, D, B, 7 every 4 cycles; frame_done pulses every 16 cycles.
- load value_in=16'h1234 mid-frame -> pending=1, digits keep showing 0000 until the wrap; from the next frame seg sequence is 33, 79, 6D, 30 for digits 0..3; pending=0.
- HEX_MODE=0, commit 16'h00A5 with blank_lz=1 -> digit0 shows 5B, digit1 shows dash 01, digits 2-3 blank 00. With blank_lz=0 -> digits 2-3 show 7E.
- load asserted exactly in the wrap cycle with 16'hBEEF, dp_in=4'b0100 -> committed at that edge, pending never rises. Digit2 shows 4F with dp_out=1; digit3 shows 1F.
- enable dropped at prescaler=2, digit_idx=1 for 10 cycles -> all outputs inactive, counters hold. After re-enable, digit 1 stays lit 2 more cycles, then digit_idx=2.
- rst asserted mid-frame with pending=1 -> next cycle digit_idx=0, pending=0, active buffer 0, outputs inactive.
